ctrl_pipe_reg: RTL and testbench

- Parametrised, registered control-signal pipeline carrying the decoded control bundle from decode through STAGES downstream stages (default EX/MEM/WB).
- Adds hazard handling: bubble (NOP) insertion, load-use stall with bubble injection, per-stage flush, stall watchdog and a saturating bubble counter.
- Sits between the control unit and the datapath pipeline registers.

---
 rtl/ctrl_pipe_reg.sv | 124 ++++++++++++
 tb/tb_ctrl_pipe_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_reg.sv
// Registered control-bundle pipeline from decode through STAGES downstream stages,
// with bubble/stall/flush hazard handling, a stall watchdog and a saturating NOP counter.
module ctrl_pipe_reg #(
  parameter int unsigned       CTRL_W    = 8,
  parameter int unsigned       STAGES    = 3,
  parameter logic [CTRL_W-1:0] NOP_VALUE = {CTRL_W{1'b0}},
  parameter int unsigned       MAX_STALL = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic                     bubble,
  input  logic                     stall,
  input  logic [STAGES-1:0]        flush_mask,
  input  logic                     clr_count,
  output logic [STAGES*CTRL_W-1:0] ctrl_out,
  output logic [STAGES-1:0]        valid_out,
  output logic                     stall_timeout,
  output logic [15:0]              bubble_count
);

  localparam int unsigned       SCNT_W    = 8;
  localparam int unsigned       BCNT_W    = 16;
  localparam logic [SCNT_W-1:0] STALL_LIM = SCNT_W'(MAX_STALL);
  localparam logic [BCNT_W-1:0] BCNT_MAX  = {BCNT_W{1'b1}};

  logic              flush1;
  logic              inject;
  logic [SCNT_W-1:0] scnt_q;
  logic [SCNT_W-1:0] scnt_d;
  logic [BCNT_W-1:0] bcnt_d;
  logic              timeout_d;

  // Stall injection into stage 1 only exists when there is a stage 1.
  generate
    if (STAGES >= 2) begin : g_multi
      assign flush1 = flush_mask[1];
    end else begin : g_single
      assign flush1 = 1'b1;
    end
  endgenerate

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CTRL_W-1:0] q;
      logic [CTRL_W-1:0] d;
      logic              vq;
      logic              vd;

      if (k == 0) begin : g_first
        always_comb begin
          d  = q;
          vd = vq;
          if (flush_mask[0]) begin
            d  = NOP_VALUE;
            vd = 1'b0;
          end else if (!stall) begin
            if (bubble) begin
              d  = NOP_VALUE;
              vd = 1'b0;
            end else begin
              d  = ctrl_in;
              vd = 1'b1;
            end
          end
        end
      end else begin : g_rest
        localparam bit IS_STAGE1 = (k == 1);
        always_comb begin
          d  = ctrl_out[(k-1)*CTRL_W +: CTRL_W];
          vd = valid_out[k-1];
          if (flush_mask[k] || (IS_STAGE1 && stall)) begin
            d  = NOP_VALUE;
            vd = 1'b0;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q  <= NOP_VALUE;
          vq <= 1'b0;
        end else begin
          q  <= d;
          vq <= vd;
        end
      end

      assign ctrl_out[k*CTRL_W +: CTRL_W] = q;
      assign valid_out[k]                 = vq;
    end
  endgenerate

  // At most one NOP injection per cycle: bubble needs !stall, stall injection needs stall.
  assign inject = (bubble && !stall && !flush_mask[0]) || (stall && !flush1);

  always_comb begin
    scnt_d    = '0;
    bcnt_d    = bubble_count;
    timeout_d = 1'b0;
    if (stall) begin
      scnt_d = (scnt_q >= STALL_LIM) ? STALL_LIM : scnt_q + SCNT_W'(1);
    end
    timeout_d = (scnt_d == STALL_LIM);
    if (clr_count) begin
      bcnt_d = '0;
    end else if (inject && (bubble_count != BCNT_MAX)) begin
      bcnt_d = bubble_count + BCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q        <= '0;
      bubble_count  <= '0;
      stall_timeout <= 1'b0;
    end else begin
      scnt_q        <= scnt_d;
      bubble_count  <= bcnt_d;
      stall_timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Directed + randomized bench for ctrl_pipe_reg against a stage-list reference model.
module tb_ctrl_pipe_reg;

  localparam int unsigned CTRL_W    = 8;
  localparam int unsigned STAGES    = 3;
  localparam int unsigned MAX_STALL = 15;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [CTRL_W-1:0]        ctrl_in;
  logic                     bubble;
  logic                     stall;
  logic [STAGES-1:0]        flush_mask;
  logic                     clr_count;
  logic [STAGES*CTRL_W-1:0] ctrl_out;
  logic [STAGES-1:0]        valid_out;
  logic                     stall_timeout;
  logic [15:0]              bubble_count;

  int checks = 0;
  int errors = 0;

  // Reference model: a list of {bundle, valid} entries plus plain integer counters.
  typedef struct {
    logic [CTRL_W-1:0] val;
    bit                ok;
  } ent_t;

  ent_t m_st [STAGES];
  int   m_bub;
  int   m_scnt;
  bit   m_to;

  ctrl_pipe_reg #(
    .CTRL_W(CTRL_W), .STAGES(STAGES), .NOP_VALUE('0), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .bubble(bubble), .stall(stall),
    .flush_mask(flush_mask), .clr_count(clr_count), .ctrl_out(ctrl_out),
    .valid_out(valid_out), .stall_timeout(stall_timeout), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) m_st[k] = '{val: '0, ok: 1'b0};
    m_bub  = 0;
    m_scnt = 0;
    m_to   = 1'b0;
  endtask

  task automatic model_step(input logic [CTRL_W-1:0] c, input logic b, input logic s,
                            input logic [STAGES-1:0] f, input logic cl);
    ent_t nxt [STAGES];
    bit   injected = 1'b0;
    // Everything advances one slot, then hazards overwrite specific slots.
    nxt[0] = '{val: c, ok: 1'b1};
    for (int k = 1; k < STAGES; k++) nxt[k] = m_st[k-1];
    if (s) begin
      nxt[0] = m_st[0];
      if (STAGES > 1) begin
        nxt[1]   = '{val: '0, ok: 1'b0};
        injected = !f[1];
      end
    end else if (b) begin
      nxt[0]   = '{val: '0, ok: 1'b0};
      injected = !f[0];
    end
    for (int k = 0; k < STAGES; k++) if (f[k]) nxt[k] = '{val: '0, ok: 1'b0};
    m_st = nxt;
    if (cl) m_bub = 0;
    else if (injected && m_bub < 65535) m_bub = m_bub + 1;
    m_scnt = s ? ((m_scnt + 1 > int'(MAX_STALL)) ? int'(MAX_STALL) : m_scnt + 1) : 0;
    m_to   = (m_scnt == int'(MAX_STALL));
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [STAGES*CTRL_W-1:0] ec;
    logic [STAGES-1:0]        ev;
    for (int k = 0; k < STAGES; k++) begin
      ec[k*CTRL_W +: CTRL_W] = m_st[k].val;
      ev[k]                  = m_st[k].ok;
    end
    cmp({tag, ".ctrl"},  32'(ctrl_out), 32'(ec));
    cmp({tag, ".valid"}, 32'(valid_out), 32'(ev));
    cmp({tag, ".tmo"},   32'(stall_timeout), 32'(m_to));
    cmp({tag, ".bcnt"},  32'(bubble_count), 32'(m_bub));
  endtask

  // Apply inputs, take one edge, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [CTRL_W-1:0] c, input logic b, input logic s,
                      input logic [STAGES-1:0] f, input logic cl);
    ctrl_in = c; bubble = b; stall = s; flush_mask = f; clr_count = cl;
    @(posedge clk);
    #1;
    model_step(c, b, s, f, cl);
  endtask

  initial begin
    int run_len;
    logic s_r;
    rst_n = 1'b0; ctrl_in = '0; bubble = 1'b0; stall = 1'b0; flush_mask = '0; clr_count = 1'b0;
    model_reset();
    #2;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Plain streaming.
    step(8'hA5, 0, 0, 3'b000, 0); check_model("s1");
    step(8'h3C, 0, 0, 3'b000, 0); check_model("s2");
    step(8'h81, 0, 0, 3'b000, 0); check_model("s3");
    cmp("stream.ctrl", 32'(ctrl_out), 32'h00A53C81);
    cmp("stream.valid", 32'(valid_out), 32'h7);

    // Single bubble walks down the pipe.
    step(8'h11, 0, 0, 3'b000, 0); check_model("b0");
    step(8'h22, 1, 0, 3'b000, 0); check_model("b1");
    cmp("bubble.st0", 32'(ctrl_out[7:0]), 32'h0);
    cmp("bubble.v0", 32'(valid_out[0]), 32'h0);
    cmp("bubble.cnt", 32'(bubble_count), 32'h1);
    step(8'h33, 0, 0, 3'b000, 0); check_model("b2");
    step(8'h44, 0, 0, 3'b000, 1); check_model("b3");
    cmp("bubble.st2", 32'(ctrl_out[23:16]), 32'h0);

    // Load-use stall: stage 0 holds 44, stage 1 takes NOPs.
    step(8'h55, 0, 1, 3'b000, 0); check_model("st1");
    step(8'h66, 1, 1, 3'b000, 0); check_model("st2");
    cmp("stall.st0", 32'(ctrl_out[7:0]), 32'h44);
    cmp("stall.st1", 32'(ctrl_out[15:8]), 32'h0);
    cmp("stall.cnt", 32'(bubble_count), 32'h2);
    cmp("stall.tmo", 32'(stall_timeout), 32'h0);

    // Flush of stages 0/1 together with stall: no injection counted.
    step(8'hA5, 0, 0, 3'b000, 0);
    step(8'h3C, 0, 0, 3'b000, 0);
    step(8'h81, 0, 0, 3'b000, 0); check_model("f0");
    step(8'h99, 0, 1, 3'b011, 0); check_model("f1");
    cmp("flush.ctrl", 32'(ctrl_out), 32'h003C0000);
    cmp("flush.valid", 32'(valid_out), 32'h4);
    cmp("flush.cnt", 32'(bubble_count), 32'h2);

    // Watchdog across a 20-cycle stall.
    step(8'h12, 0, 0, 3'b000, 0); check_model("w0");
    for (int i = 1; i <= 20; i++) begin
      step(8'(i), 0, 1, 3'b000, 0);
      check_model("wd");
      cmp("wd.edge", 32'(stall_timeout), (i >= 15) ? 32'h1 : 32'h0);
    end
    step(8'h13, 0, 0, 3'b000, 0); check_model("wd.rel");
    cmp("wd.fall", 32'(stall_timeout), 32'h0);

    // Counter saturation and clear priority.
    step(8'h00, 0, 0, 3'b000, 1);
    for (int i = 0; i < 65535; i++) step(8'h00, 1, 0, 3'b000, 0);
    check_model("sat0");
    cmp("sat.full", 32'(bubble_count), 32'hFFFF);
    step(8'h00, 1, 0, 3'b000, 0); check_model("sat1");
    cmp("sat.hold", 32'(bubble_count), 32'hFFFF);
    step(8'h00, 1, 0, 3'b000, 1); check_model("clr");
    cmp("clr.prio", 32'(bubble_count), 32'h0);

    // Randomized traffic with occasional long stalls.
    run_len = 0;
    s_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (run_len == 0) begin
        s_r = ($urandom_range(0, 3) == 0);
        run_len = s_r ? (($urandom_range(0, 7) == 0) ? 18 : $urandom_range(1, 3))
                      : $urandom_range(1, 6);
      end
      run_len--;
      step(8'($urandom), ($urandom_range(0, 3) == 0), s_r,
           {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)},
           ($urandom_range(0, 40) == 0));
      check_model("rnd");
    end

    // Asynchronous reset mid-stream, away from any edge.
    step(8'hC3, 0, 0, 3'b000, 0);
    step(8'h5A, 1, 1, 3'b000, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("areset");
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h77, 0, 0, 3'b000, 0); check_model("post");
    cmp("post.st0", 32'(ctrl_out), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
